// File: rtl/cfg_loader_pkg.sv
// Shared types and constants for the configuration bitstream loader.
package cfg_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_SETUP,
        ST_STROBE,
        ST_GAP,
        ST_DONE
    } cfg_state_t;

    localparam int SETUP_CYCLES_DEF = 2;
    localparam int GAP_CYCLES_DEF   = 2;
    localparam int CFG_WORD_W       = 32;
    localparam int MAX_BITBYTES     = 21140;

endpackage

// File: rtl/cfg_bitstream_writer_if.sv
// Byte-stream valid/ready handshake feeding the bitstream writer.
interface cfg_bitstream_writer_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/cfg_word_packer.sv
// Packs accepted bytes big-endian into a 32-bit word; a short final word is zero-padded.
module cfg_word_packer
    import cfg_loader_pkg::*;
(
    input  logic                  CLK,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic                  last_byte,
    input  logic [7:0]            byte_in,
    output logic                  word_ready,
    output logic [CFG_WORD_W-1:0] word
);

    logic [23:0]           sh_q;
    logic [1:0]            idx_q;
    logic [CFG_WORD_W-1:0] joined;
    logic [4:0]            pad_sh;

    assign word_ready = shift_en & ((idx_q == 2'd3) | last_byte);

    // Earlier bytes sit above the current one; shifting left moves the first byte to [31:24].
    assign joined = {sh_q, byte_in};
    assign pad_sh = {2'd3 - idx_q, 3'b000};
    assign word   = joined << pad_sh;

    always_ff @(posedge CLK) begin
        if (clear || word_ready) begin
            sh_q  <= '0;
            idx_q <= '0;
        end else if (shift_en) begin
            sh_q  <= {sh_q[15:0], byte_in};
            idx_q <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/cfg_bitstream_writer.sv
// Bitstream master: packs a byte stream into words and drives SelfWriteData/SelfWriteStrobe.
//   state   | meaning
//   IDLE    | no load since reset
//   COLLECT | accepting bytes into the packer
//   SETUP   | word on SelfWriteData, waiting before the strobe
//   STROBE  | one-cycle write pulse
//   GAP     | data held after the strobe
//   DONE    | load finished, done high
module cfg_bitstream_writer
    import cfg_loader_pkg::*;
#(
    parameter int SETUP_CYCLES = SETUP_CYCLES_DEF,
    parameter int GAP_CYCLES   = GAP_CYCLES_DEF,
    parameter int LEN_W        = 15
) (
    input  logic                  CLK,
    input  logic                  rst_sync_cfg,
    input  logic                  start,
    input  logic [LEN_W-1:0]      byte_count,
    cfg_bitstream_writer_if.slave byte_in,
    output logic [CFG_WORD_W-1:0] SelfWriteData,
    output logic                  SelfWriteStrobe,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_W-2:0]      words_written
);

    localparam int TMR_MAX = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    cfg_state_t            state_q, state_d;
    logic [TMR_W-1:0]      tmr_q;
    logic [LEN_W-1:0]      bytes_left_q;
    logic                  in_ready_q;
    logic                  in_ready_d, strobe_d, busy_d, done_d;
    logic                  start_go, accept, last_byte, word_ready, pack_clear;
    logic [CFG_WORD_W-1:0] packed_word;

    assign start_go   = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    assign accept     = byte_in.in_valid & in_ready_q;
    assign last_byte  = (bytes_left_q == LEN_W'(1));
    assign pack_clear = rst_sync_cfg | start_go;

    assign byte_in.in_ready = in_ready_q;

    cfg_word_packer u_packer (
        .CLK        (CLK),
        .clear      (pack_clear),
        .shift_en   (accept),
        .last_byte  (last_byte),
        .byte_in    (byte_in.in_data),
        .word_ready (word_ready),
        .word       (packed_word)
    );

    always_ff @(posedge CLK) begin
        if (rst_sync_cfg) state_q <= ST_IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = (byte_count == '0) ? ST_DONE : ST_COLLECT;
            ST_COLLECT:       if (word_ready) state_d = ST_SETUP;
            ST_SETUP:         if (tmr_q == '0) state_d = ST_STROBE;
            ST_STROBE:        state_d = ST_GAP;
            ST_GAP:           if (tmr_q == '0) state_d = (bytes_left_q == '0) ? ST_DONE : ST_COLLECT;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        in_ready_d = (state_d == ST_COLLECT);
        strobe_d   = (state_d == ST_STROBE);
        busy_d     = (state_d == ST_COLLECT) | (state_d == ST_SETUP) |
                     (state_d == ST_STROBE)  | (state_d == ST_GAP);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK) begin
        if (rst_sync_cfg) begin
            in_ready_q      <= 1'b0;
            SelfWriteStrobe <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            SelfWriteData   <= '0;
            words_written   <= '0;
            bytes_left_q    <= '0;
            tmr_q           <= '0;
        end else begin
            in_ready_q      <= in_ready_d;
            SelfWriteStrobe <= strobe_d;
            busy            <= busy_d;
            done            <= done_d;

            if (word_ready) SelfWriteData <= packed_word;

            if (start_go) begin
                bytes_left_q  <= byte_count;
                words_written <= '0;
            end else begin
                if (accept) bytes_left_q <= bytes_left_q - LEN_W'(1);
                if (state_q == ST_STROBE) words_written <= words_written + (LEN_W-1)'(1);
            end

            // Down-counter reloaded on entry to SETUP and GAP; terminal count at zero.
            if (state_q == ST_COLLECT && state_d == ST_SETUP) tmr_q <= TMR_W'(SETUP_CYCLES - 1);
            else if (state_q == ST_STROBE)                    tmr_q <= TMR_W'(GAP_CYCLES - 1);
            else if (tmr_q != '0)                             tmr_q <= tmr_q - TMR_W'(1);
        end
    end

endmodule

// File: tb/tb_cfg_bitstream_writer.sv
// Directed bench for cfg_bitstream_writer: word packing, strobe timing, restart, reset and empty loads.
module tb_cfg_bitstream_writer;

    localparam int LEN_W = 15;

    logic              CLK = 1'b0;
    logic              rst_sync_cfg;
    logic              start;
    logic [LEN_W-1:0]  byte_count;
    logic [31:0]       SelfWriteData;
    logic              SelfWriteStrobe;
    logic              busy;
    logic              done;
    logic [LEN_W-2:0]  words_written;

    cfg_bitstream_writer_if bif ();

    cfg_bitstream_writer #(.SETUP_CYCLES(2), .GAP_CYCLES(2), .LEN_W(LEN_W)) dut (
        .CLK             (CLK),
        .rst_sync_cfg    (rst_sync_cfg),
        .start           (start),
        .byte_count      (byte_count),
        .byte_in         (bif),
        .SelfWriteData   (SelfWriteData),
        .SelfWriteStrobe (SelfWriteStrobe),
        .busy            (busy),
        .done            (done),
        .words_written   (words_written)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Strobe monitor: records strobed words and checks setup/hold/width timing.
    logic [31:0] mon_words [$];
    bit          mon_rst = 1'b1;
    logic [31:0] prev_data = '0;
    logic        prev_strobe = 1'b0;
    int          since_chg = 99;
    int          since_strobe = 99;

    always @(negedge CLK) begin
        if (mon_rst) begin
            prev_data    = SelfWriteData;
            prev_strobe  = 1'b0;
            since_chg    = 99;
            since_strobe = 99;
        end else begin
            if (SelfWriteData !== prev_data) begin
                chk("hold_after_strobe", since_strobe >= 2, 1);
                since_chg = 0;
                prev_data = SelfWriteData;
            end else begin
                since_chg++;
            end
            since_strobe++;
            if (SelfWriteStrobe) begin
                chk("setup_cycles", since_chg, 2);
                chk("strobe_width", prev_strobe, 0);
                mon_words.push_back(SelfWriteData);
                since_strobe = 0;
            end
            prev_strobe = SelfWriteStrobe;
        end
    end

    logic [7:0] bytes [0:15];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_bytes(input logic [7:0] first);
        for (int k = 0; k < 16; k++) bytes[k] = first + 8'(k);
    endtask

    task automatic run_load(input int n, input int stall_at, input int stall_len, input bit poke);
        int i = 0;
        int stalled = 0;
        int cyc = 0;
        bit hs;
        mon_words.delete();
        start = 1'b1;
        byte_count = LEN_W'(n);
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_cleared", done, 0);
        while (i < n && cyc < 400) begin
            start      = poke && (cyc == 3);
            byte_count = (poke && (cyc == 3)) ? LEN_W'(4) : LEN_W'(n);
            if (i == stall_at && stalled < stall_len) begin
                bif.in_valid = 1'b0;
                stalled++;
            end else begin
                bif.in_valid = 1'b1;
                bif.in_data  = bytes[i];
            end
            hs = bif.in_valid && bif.in_ready;
            tick();
            if (hs) i++;
            cyc++;
            if (stall_len > 0 && stalled == stall_len && i == stall_at)
                chk("no_early_strobe", mon_words.size(), 0);
        end
        start = 1'b0;
        bif.in_valid = 1'b0;
        chk("all_bytes_taken", i, n);
        cyc = 0;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("done_reached", done, 1);
        chk("busy_cleared", busy, 0);
        chk("in_ready_low", bif.in_ready, 0);
    endtask

    task automatic check_words(input int nw, input logic [31:0] w0, input logic [31:0] w1, input int ww);
        chk("word_count", mon_words.size(), nw);
        chk("word0", (mon_words.size() > 0) ? mon_words[0] : 32'hxxxxxxxx, w0);
        if (nw > 1) chk("word1", (mon_words.size() > 1) ? mon_words[1] : 32'hxxxxxxxx, w1);
        chk("words_written", 32'(words_written), ww);
    endtask

    initial begin
        int k;
        int cyc;
        bit hs;
        rst_sync_cfg = 1'b1;
        start        = 1'b0;
        byte_count   = '0;
        bif.in_valid = 1'b0;
        bif.in_data  = '0;
        tick();
        tick();
        chk("rst_in_ready", bif.in_ready, 0);
        chk("rst_data", SelfWriteData, 0);
        chk("rst_strobe", SelfWriteStrobe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_words", 32'(words_written), 0);
        rst_sync_cfg = 1'b0;
        tick();
        mon_rst = 1'b0;

        set_bytes(8'h01);
        run_load(8, -1, 0, 1'b0);
        check_words(2, 32'h01020304, 32'h05060708, 2);

        bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC;
        bytes[3] = 8'hDD; bytes[4] = 8'hEE; bytes[5] = 8'hFF;
        run_load(6, -1, 0, 1'b0);
        check_words(2, 32'hAABBCCDD, 32'hEEFF0000, 2);

        set_bytes(8'h01);
        run_load(8, 2, 5, 1'b0);
        check_words(2, 32'h01020304, 32'h05060708, 2);

        set_bytes(8'h10);
        run_load(8, -1, 0, 1'b1);
        check_words(2, 32'h10111213, 32'h14151617, 2);

        set_bytes(8'h01);
        run_load(5, -1, 0, 1'b0);
        check_words(2, 32'h01020304, 32'h05000000, 2);

        // Empty load started from DONE.
        mon_words.delete();
        start = 1'b1;
        byte_count = '0;
        tick();
        start = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_in_ready", bif.in_ready, 0);
        repeat (5) tick();
        chk("zero_no_strobe", mon_words.size(), 0);
        chk("zero_in_ready_later", bif.in_ready, 0);

        // Reset during the first strobe of a load.
        set_bytes(8'h01);
        mon_words.delete();
        start = 1'b1;
        byte_count = LEN_W'(8);
        tick();
        start = 1'b0;
        k = 0;
        cyc = 0;
        while (!SelfWriteStrobe && cyc < 50) begin
            bif.in_valid = 1'b1;
            bif.in_data  = bytes[k];
            hs = bif.in_valid && bif.in_ready;
            tick();
            if (hs) k++;
            cyc++;
        end
        chk("strobe_seen", SelfWriteStrobe, 1);
        rst_sync_cfg = 1'b1;
        bif.in_valid = 1'b0;
        tick();
        mon_rst = 1'b1;
        chk("mid_rst_strobe", SelfWriteStrobe, 0);
        chk("mid_rst_data", SelfWriteData, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_in_ready", bif.in_ready, 0);
        chk("mid_rst_words", 32'(words_written), 0);
        chk("strobes_before_rst", mon_words.size(), 1);
        rst_sync_cfg = 1'b0;
        tick();
        mon_rst = 1'b0;

        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        run_load(4, -1, 0, 1'b0);
        check_words(1, 32'h11223344, 32'h0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
